// File: rtl/operand_loader_pkg.sv
// operand_loader_pkg: shared types and constants for the operand loader slice.
//   state_t       - capture FSM state encoding
//   OPERAND_WIDTH - default operand width (matches mux_2to1 data width)
package operand_loader_pkg;

  localparam int OPERAND_WIDTH = 4;

  typedef enum logic [1:0] {
    S_LOAD_D0 = 2'd0,
    S_LOAD_D1 = 2'd1,
    S_READY   = 2'd2
  } state_t;

endpackage

// File: rtl/operand_loader_if.sv
// operand_loader_if: switch/button inputs and mux-facing outputs of operand_loader.
//   sw       - raw switch value (operand source)
//   btn_load - raw load button
//   btn_sel  - raw select-toggle button
//   d0, d1   - captured operands for mux_2to1
//   sel      - mux select
//   ready    - both operands valid
// master: board/stimulus side; slave: operand_loader side.
interface operand_loader_if
  import operand_loader_pkg::*;
#(
  parameter int WIDTH = OPERAND_WIDTH
);
  logic [WIDTH-1:0] sw;
  logic             btn_load;
  logic             btn_sel;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             sel;
  logic             ready;

  modport master (output sw, btn_load, btn_sel, input d0, d1, sel, ready);
  modport slave  (input sw, btn_load, btn_sel, output d0, d1, sel, ready);
endinterface

// File: rtl/operand_loader_debouncer.sv
// button_debouncer: synchronizes a raw bouncy button and accepts a level change
// only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
//   clk, rst - clock, synchronous active-high reset
//   btn_raw  - asynchronous raw button
//   level    - debounced stable level
//   pulse    - one-cycle strobe on the stable 0->1 transition
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // The edge that would bring the count to DEBOUNCE_CYCLES flips the level.
        level <= sync2;
        cnt   <= '0;
        pulse <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/operand_loader.sv
// operand_loader: captures two operands from switches on debounced load presses
// and drives mux_2to1 d0/d1/sel; a debounced select button toggles sel in S_READY.
//   clk, rst - clock, synchronous active-high reset
//   bus      - operand_loader_if slave (sw, btn_load, btn_sel -> d0, d1, sel, ready)
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int WIDTH           = OPERAND_WIDTH,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  operand_loader_if.slave   bus
);
  logic load_pulse, sel_pulse;
  logic load_level, sel_level;
  logic unused_levels;

  state_t           state, state_n;
  logic [WIDTH-1:0] d0_q, d0_n, d1_q, d1_n;
  logic             sel_q, sel_n, ready_q;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_load), .level(load_level), .pulse(load_pulse)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sel_db (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_sel), .level(sel_level), .pulse(sel_pulse)
  );

  assign unused_levels = load_level ^ sel_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_LOAD_D0;
      d0_q    <= '0;
      d1_q    <= '0;
      sel_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_n;
      d0_q    <= d0_n;
      d1_q    <= d1_n;
      sel_q   <= sel_n;
      ready_q <= (state_n == S_READY);
    end
  end

  always_comb begin
    state_n = state;
    d0_n    = d0_q;
    d1_n    = d1_q;
    sel_n   = sel_q;
    case (state)
      S_LOAD_D0: begin
        if (load_pulse) begin
          d0_n    = bus.sw;
          state_n = S_LOAD_D1;
        end
      end
      S_LOAD_D1: begin
        if (load_pulse) begin
          d1_n    = bus.sw;
          state_n = S_READY;
        end
      end
      S_READY: begin
        // Load wins over a coincident select press.
        if (load_pulse) begin
          d0_n    = bus.sw;
          state_n = S_LOAD_D1;
        end else if (sel_pulse) begin
          sel_n = ~sel_q;
        end
      end
      default: state_n = S_LOAD_D0;
    endcase
  end

  assign bus.d0    = d0_q;
  assign bus.d1    = d1_q;
  assign bus.sel   = sel_q;
  assign bus.ready = ready_q;
endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: directed self-checking bench for operand_loader (DEBOUNCE_CYCLES=4).
module tb_operand_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   load_pulses = 0;
  int   sel_pulses = 0;
  logic [3:0] y;

  always #5 clk = ~clk;

  operand_loader_if #(.WIDTH(4)) bus ();

  operand_loader #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Reference behaviour of the downstream mux_2to1.
  assign y = bus.sel ? bus.d1 : bus.d0;

  always @(negedge clk) begin
    if (dut.u_load_db.pulse) load_pulses++;
    if (dut.u_sel_db.pulse) sel_pulses++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Finish a 10-cycle press (7 already spent) and a 10-cycle release.
  task automatic release_all();
    tick(3);
    bus.btn_load = 1'b0;
    bus.btn_sel  = 1'b0;
    tick(10);
  endtask

  initial begin
    bus.sw       = 4'h0;
    bus.btn_load = 1'b0;
    bus.btn_sel  = 1'b0;

    // Reset
    tick(3);
    rst = 1'b0;
    check("rst_d0", 8'(bus.d0), 8'h0);
    check("rst_d1", 8'(bus.d1), 8'h0);
    check("rst_sel", 8'(bus.sel), 8'h0);
    check("rst_ready", 8'(bus.ready), 8'h0);
    load_pulses = 0;
    sel_pulses  = 0;
    tick(20);
    check("idle_pulses", 8'(load_pulses + sel_pulses), 8'h0);

    // Load d0: visible on the 7th edge after the press is driven
    bus.sw = 4'hF;
    bus.btn_load = 1'b1;
    tick(6);
    check("d0_early", 8'(bus.d0), 8'h0);
    tick(1);
    check("d0_load", 8'(bus.d0), 8'hF);
    check("d0_ready", 8'(bus.ready), 8'h0);
    release_all();

    // Load d1, ready rises on the same edge
    bus.sw = 4'hB;
    bus.btn_load = 1'b1;
    tick(6);
    check("d1_early", 8'(bus.d1), 8'h0);
    check("ready_early", 8'(bus.ready), 8'h0);
    tick(1);
    check("d1_load", 8'(bus.d1), 8'hB);
    check("ready_up", 8'(bus.ready), 8'h1);
    release_all();

    // Select toggles
    bus.btn_sel = 1'b1;
    tick(6);
    check("sel_early", 8'(bus.sel), 8'h0);
    tick(1);
    check("sel_1", 8'(bus.sel), 8'h1);
    check("y_d1", 8'(y), 8'hB);
    release_all();
    bus.btn_sel = 1'b1;
    tick(7);
    check("sel_0", 8'(bus.sel), 8'h0);
    check("y_d0", 8'(y), 8'hF);
    release_all();
    bus.btn_sel = 1'b1;
    tick(7);
    check("sel_1b", 8'(bus.sel), 8'h1);
    release_all();

    // Simultaneous load + sel in S_READY: load wins, sel held
    bus.sw = 4'h5;
    bus.btn_load = 1'b1;
    bus.btn_sel  = 1'b1;
    tick(7);
    check("sim_d0", 8'(bus.d0), 8'h5);
    check("sim_d1", 8'(bus.d1), 8'hB);
    check("sim_ready", 8'(bus.ready), 8'h0);
    check("sim_sel", 8'(bus.sel), 8'h1);
    check("sim_state", 8'(dut.state), 8'h1);
    release_all();

    // Sel ignored in S_LOAD_D1
    bus.btn_sel = 1'b1;
    tick(7);
    check("sel_ign_d1", 8'(bus.sel), 8'h1);
    release_all();
    bus.sw = 4'h3;
    bus.btn_load = 1'b1;
    tick(7);
    check("reload_d1", 8'(bus.d1), 8'h3);
    check("reload_ready", 8'(bus.ready), 8'h1);
    check("reload_sel", 8'(bus.sel), 8'h1);
    release_all();

    // Bounce rejection from a fresh reset
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    load_pulses = 0;
    bus.sw = 4'h9;
    for (int i = 0; i < 4; i++) begin
      bus.btn_load = 1'b1;
      tick(2);
      bus.btn_load = 1'b0;
      tick(1);
    end
    bus.btn_load = 1'b1;
    tick(20);
    bus.btn_load = 1'b0;
    tick(10);
    check("bounce_pulses", 8'(load_pulses), 8'h1);
    check("bounce_d0", 8'(bus.d0), 8'h9);
    check("bounce_d1", 8'(bus.d1), 8'h0);
    check("bounce_ready", 8'(bus.ready), 8'h0);

    // Sel ignored in S_LOAD_D0 (after reset)
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    bus.btn_sel = 1'b1;
    tick(7);
    check("sel_ign_d0", 8'(bus.sel), 8'h0);
    release_all();

    // Reach S_LOAD_D1 with sel set, then reset mid-debounce
    bus.sw = 4'h6;
    bus.btn_load = 1'b1;
    tick(7);
    release_all();
    bus.sw = 4'hA;
    bus.btn_load = 1'b1;
    tick(7);
    release_all();
    bus.btn_sel = 1'b1;
    tick(7);
    check("pre_rst_sel", 8'(bus.sel), 8'h1);
    release_all();
    bus.sw = 4'hC;
    bus.btn_load = 1'b1;
    tick(7);
    check("pre_rst_d0", 8'(bus.d0), 8'hC);
    release_all();
    bus.sw = 4'h7;
    bus.btn_load = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(2);
    check("mid_rst_d0", 8'(bus.d0), 8'h0);
    check("mid_rst_d1", 8'(bus.d1), 8'h0);
    check("mid_rst_sel", 8'(bus.sel), 8'h0);
    check("mid_rst_ready", 8'(bus.ready), 8'h0);
    rst = 1'b0;
    tick(6);
    check("post_rst_early", 8'(bus.d0), 8'h0);
    tick(1);
    check("post_rst_d0", 8'(bus.d0), 8'h7);
    check("post_rst_ready", 8'(bus.ready), 8'h0);
    release_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
